// File: rtl/audio_pkg.sv
// Shared audio constants, FSM state type and slot-bit helper for the WM8731 I2S
// transmit path (and future receive blocks).
package audio_pkg;

  localparam int unsigned DATA_W       = 24;
  localparam int unsigned SLOT_W       = 32;
  localparam int unsigned CLK_PER_BCLK = 16;

  localparam int unsigned BCLK_SH   = $clog2(CLK_PER_BCLK);
  localparam int unsigned SLOT_SH   = $clog2(SLOT_W);
  localparam int unsigned CNT_W     = BCLK_SH + SLOT_SH + 1;
  localparam int unsigned FRAME_LEN = 2 * SLOT_W * CLK_PER_BCLK;
  localparam int unsigned POS_W     = $clog2(DATA_W);

  typedef enum logic {IDLE, RUN} state_e;

  // Bit k of an I2S slot: MSB at k=1 (one-BCLK delay after LRCK), zero padding elsewhere.
  function automatic logic slot_bit(input logic [DATA_W-1:0] sample,
                                    input logic [SLOT_SH-1:0] k);
    int unsigned       ki;
    logic [POS_W-1:0]  pos;
    ki = 32'(k);
    if (ki == 0 || ki > DATA_W) return 1'b0;
    pos = POS_W'(DATA_W - ki);
    return sample[pos];
  endfunction

endpackage

// File: rtl/i2s_dac_tx_if.sv
// Valid/ready stream carrying one left/right sample pair per transfer.
interface i2s_dac_tx_if;
  import audio_pkg::*;

  logic [DATA_W-1:0] s_left;
  logic [DATA_W-1:0] s_right;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_left, output s_right, output s_valid, input s_ready);
  modport slave  (input s_left, input s_right, input s_valid, output s_ready);

endinterface

// File: rtl/i2s_phase_gen.sv
// Frame phase counter plus registered XCK/BCLK/LRCK and the frame-load strobe.
module i2s_phase_gen
  import audio_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               adv_i,
  output logic               frame_load_o,
  output logic               chan_nxt_o,
  output logic [SLOT_SH-1:0] k_nxt_o,
  output logic               xck_o,
  output logic               bclk_o,
  output logic               lrck_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             xck_q, bclk_q, lrck_q;

  always_comb begin
    cnt_d = '0;
    if (adv_i) cnt_d = cnt_q + 1'b1;
  end

  assign frame_load_o = adv_i && (cnt_q == CNT_W'(FRAME_LEN - 1));
  assign chan_nxt_o   = cnt_d[CNT_W-1];
  assign k_nxt_o      = cnt_d[CNT_W-2 -: SLOT_SH];

  // Clock outputs are taken from the next count so they move on the same edge as cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      xck_q  <= 1'b0;
      bclk_q <= 1'b0;
      lrck_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      xck_q  <= cnt_d[1];
      bclk_q <= cnt_d[BCLK_SH-1];
      lrck_q <= cnt_d[CNT_W-1];
    end
  end

  assign xck_o  = xck_q;
  assign bclk_o = bclk_q;
  assign lrck_o = lrck_q;

endmodule

// File: rtl/i2s_dac_tx.sv
// WM8731 I2S 24-bit DAC serializer: run/idle FSM, one-entry hold buffer, per-frame
// sample load with bypass and underrun counting, registered serial data.
module i2s_dac_tx
  import audio_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_done_i,
  i2s_dac_tx_if.slave        s_if,
  output logic               aud_xck_o,
  output logic               aud_bclk_o,
  output logic               aud_daclrck_o,
  output logic               aud_dacdat_o,
  output logic [15:0]        underrun_cnt_o
);

  state_e            state_q;
  logic              hold_full_q;
  logic [DATA_W-1:0] hold_l_q, hold_r_q;
  logic [DATA_W-1:0] sh_l_q, sh_r_q, sh_l_d, sh_r_d;
  logic              dacdat_q, dacdat_d;
  logic [15:0]       underrun_q;

  logic               adv, frame_load, hs, chan_nxt;
  logic [SLOT_SH-1:0] k_nxt;
  logic [DATA_W-1:0]  ch_sample;

  assign adv         = (state_q == RUN) && cfg_done_i;
  assign s_if.s_ready = (state_q == RUN) && !hold_full_q;
  assign hs          = s_if.s_valid && s_if.s_ready;

  i2s_phase_gen u_phase (
    .clk          (clk),
    .rst          (rst),
    .adv_i        (adv),
    .frame_load_o (frame_load),
    .chan_nxt_o   (chan_nxt),
    .k_nxt_o      (k_nxt),
    .xck_o        (aud_xck_o),
    .bclk_o       (aud_bclk_o),
    .lrck_o       (aud_daclrck_o)
  );

  // Frame load priority: hold register, then direct bypass of the input, else silence.
  always_comb begin
    sh_l_d = sh_l_q;
    sh_r_d = sh_r_q;
    if (!adv) begin
      sh_l_d = '0;
      sh_r_d = '0;
    end else if (frame_load) begin
      if (hold_full_q) begin
        sh_l_d = hold_l_q;
        sh_r_d = hold_r_q;
      end else if (s_if.s_valid) begin
        sh_l_d = s_if.s_left;
        sh_r_d = s_if.s_right;
      end else begin
        sh_l_d = '0;
        sh_r_d = '0;
      end
    end
    ch_sample = chan_nxt ? sh_r_d : sh_l_d;
    dacdat_d  = adv && slot_bit(ch_sample, k_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      sh_l_q      <= '0;
      sh_r_q      <= '0;
      dacdat_q    <= 1'b0;
      underrun_q  <= '0;
    end else begin
      sh_l_q   <= sh_l_d;
      sh_r_q   <= sh_r_d;
      dacdat_q <= dacdat_d;
      unique case (state_q)
        IDLE: begin
          hold_full_q <= 1'b0;
          if (cfg_done_i) state_q <= RUN;
        end
        RUN: begin
          if (!cfg_done_i) begin
            state_q     <= IDLE;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
          end else if (frame_load) begin
            hold_full_q <= 1'b0;
            if (!hold_full_q && !s_if.s_valid && underrun_q != 16'hFFFF) begin
              underrun_q <= underrun_q + 16'd1;
            end
          end else if (hs) begin
            hold_full_q <= 1'b1;
            hold_l_q    <= s_if.s_left;
            hold_r_q    <= s_if.s_right;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign aud_dacdat_o   = dacdat_q;
  assign underrun_cnt_o = underrun_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx: decodes the I2S wire on BCLK rising edges and
// compares decoded frames, counters and idle/reset levels with hand-derived values.
module tb_i2s_dac_tx;
  import audio_pkg::*;

  localparam int NS = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_done = 1'b0;
  logic        aud_xck, aud_bclk, aud_daclrck, aud_dacdat;
  logic [15:0] underrun_cnt;

  i2s_dac_tx_if s_if ();

  i2s_dac_tx dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_done_i     (cfg_done),
    .s_if           (s_if.slave),
    .aud_xck_o      (aud_xck),
    .aud_bclk_o     (aud_bclk),
    .aud_daclrck_o  (aud_daclrck),
    .aud_dacdat_o   (aud_dacdat),
    .underrun_cnt_o (underrun_cnt)
  );

  always #10 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Wire decoder
  logic [DATA_W-1:0] dec_l[$];
  logic [DATA_W-1:0] dec_r[$];
  int                restart_id = 0;
  int                seen_id = 0;
  int                idx = 0;
  int                cyc = 0;
  int                lr_last = 0;
  bit                lr_ok = 0, lr_prev = 0, bclk_prev = 0, slot_lr = 0;
  logic [DATA_W-1:0] acc = '0, left_acc = '0;

  always @(negedge clk) begin
    cyc++;
    if (aud_daclrck && !lr_prev) begin
      if (lr_ok) check_eq("lrck_period", 32'(cyc - lr_last), 32'd1024);
      lr_last = cyc;
      lr_ok   = 1'b1;
    end
    lr_prev = aud_daclrck;
    if (aud_bclk && !bclk_prev) begin
      if (seen_id != restart_id) begin
        seen_id = restart_id;
        idx     = 0;
        lr_ok   = 1'b0;
      end else if (aud_daclrck != slot_lr) begin
        idx = 0;
      end else begin
        idx++;
      end
      slot_lr = aud_daclrck;
      if (idx >= 1 && idx <= 24) acc = {acc[DATA_W-2:0], aud_dacdat};
      else check_eq("pad_bit", 32'(aud_dacdat), 32'd0);
      if (idx == 31) begin
        if (!slot_lr) begin
          left_acc = acc;
        end else begin
          dec_l.push_back(left_acc);
          dec_r.push_back(acc);
        end
      end
    end
    bclk_prev = aud_bclk;
  end

  // Returns at negedge+1 right after frame n-1's last right bit (cnt == 1016).
  task automatic wait_frames(input int n);
    int t = 0;
    int lim;
    lim = 1100 * (n - dec_l.size()) + 2000;
    while (dec_l.size() < n && t < lim) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (dec_l.size() < n) check_eq("frame_timeout", 32'(dec_l.size()), 32'(n));
  endtask

  task automatic check_frame(input int i, input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    if (i < dec_l.size()) begin
      check_eq("frame_l", 32'(dec_l[i]), 32'(l));
      check_eq("frame_r", 32'(dec_r[i]), 32'(r));
    end else begin
      check_eq("frame_missing", 32'(dec_l.size()), 32'(i + 1));
    end
  endtask

  task automatic send_pair(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    int t = 0;
    s_if.s_left  = l;
    s_if.s_right = r;
    s_if.s_valid = 1'b1;
    while (!s_if.s_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!s_if.s_ready) check_eq("ready_timeout", 32'(s_if.s_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    s_if.s_valid = 1'b0;
  endtask

  // Caller guarantees the next posedge samples cfg_done=1 from IDLE.
  task automatic start_run_check();
    int n = 0;
    restart_id++;
    @(posedge clk);
    #1;
    while (!aud_bclk && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("first_bclk", 32'(n), 32'd8);
  endtask

  function automatic logic [4:0] outs();
    return {aud_xck, aud_bclk, aud_daclrck, aud_dacdat, s_if.s_ready};
  endfunction

  initial begin
    int fb;
    logic [4:0] orv;
    s_if.s_left  = '0;
    s_if.s_right = '0;
    s_if.s_valid = 1'b0;
    #5 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_outs", 32'(outs()), 32'd0);
    check_eq("reset_underrun", 32'(underrun_cnt), 32'd0);

    // Held in IDLE with a valid pair offered
    rst = 1'b0;
    s_if.s_left  = 24'h123456;
    s_if.s_right = 24'h654321;
    s_if.s_valid = 1'b1;
    orv = '0;
    repeat (5000) begin
      @(negedge clk);
      orv = orv | outs();
    end
    check_eq("idle_outs", 32'(orv), 32'd0);
    check_eq("idle_underrun", 32'(underrun_cnt), 32'd0);

    // Single pair: silence, pair, underrun
    s_if.s_valid = 1'b0;
    fb = dec_l.size();
    cfg_done = 1'b1;
    start_run_check();
    send_pair(24'h800001, 24'h7FFFFE);
    wait_frames(fb + 3);
    check_frame(fb + 0, 24'h000000, 24'h000000);
    check_frame(fb + 1, 24'h800001, 24'h7FFFFE);
    check_frame(fb + 2, 24'h000000, 24'h000000);
    check_eq("underrun_single", 32'(underrun_cnt), 32'd1);

    // Continuous stream
    for (int n = 0; n < NS; n++) send_pair(24'h100000 + 24'(n), 24'hF00000 + 24'(n));
    wait_frames(fb + 3 + NS);
    for (int n = 0; n < NS; n++) check_frame(fb + 3 + n, 24'h100000 + 24'(n), 24'hF00000 + 24'(n));
    check_eq("underrun_stream", 32'(underrun_cnt), 32'd1);

    // Three starved frames, then resume
    wait_frames(fb + 6 + NS);
    check_eq("underrun_starve", 32'(underrun_cnt), 32'd4);
    for (int n = 0; n < 3; n++) send_pair(24'hABC000 + 24'(n), 24'h123000 + 24'(n));
    wait_frames(fb + 9 + NS);
    for (int n = 0; n < 3; n++) check_frame(fb + 3 + NS + n, 24'h000000, 24'h000000);
    for (int n = 0; n < 3; n++) check_frame(fb + 6 + NS + n, 24'hABC000 + 24'(n), 24'h123000 + 24'(n));
    check_eq("underrun_resume", 32'(underrun_cnt), 32'd4);

    // Bypass: valid only on the cnt=1023 cycle
    repeat (7) @(negedge clk);
    s_if.s_left  = 24'h5A5A5A;
    s_if.s_right = 24'hA5A5A5;
    s_if.s_valid = 1'b1;
    check_eq("ready_at_1023", 32'(s_if.s_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    s_if.s_valid = 1'b0;
    wait_frames(fb + 10 + NS);
    check_frame(fb + 9 + NS, 24'h5A5A5A, 24'hA5A5A5);
    check_eq("underrun_bypass", 32'(underrun_cnt), 32'd4);

    // Reset at cnt=500 of the next (starved) frame
    repeat (508) @(negedge clk);
    check_eq("underrun_pre_rst", 32'(underrun_cnt), 32'd5);
    rst = 1'b1;
    #1;
    check_eq("midrst_outs", 32'(outs()), 32'd0);
    check_eq("midrst_underrun", 32'(underrun_cnt), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("rst_held_outs", 32'(outs()), 32'd0);
    fb = dec_l.size();
    rst = 1'b0;
    start_run_check();
    send_pair(24'h7FFFFF, 24'h800000);
    wait_frames(fb + 2);
    check_frame(fb + 0, 24'h000000, 24'h000000);
    check_frame(fb + 1, 24'h7FFFFF, 24'h800000);
    check_eq("underrun_after_rst", 32'(underrun_cnt), 32'd0);

    // cfg_done dropped mid-frame after one more underrun
    repeat (100) @(negedge clk);
    cfg_done = 1'b0;
    @(negedge clk);
    check_eq("cfgdrop_outs", 32'(outs()), 32'd0);
    check_eq("cfgdrop_underrun", 32'(underrun_cnt), 32'd1);
    repeat (50) @(negedge clk);
    check_eq("cfgdrop_idle_outs", 32'(outs()), 32'd0);
    check_eq("cfgdrop_idle_underrun", 32'(underrun_cnt), 32'd1);
    cfg_done = 1'b1;
    start_run_check();
    check_eq("rerun_underrun", 32'(underrun_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2s_dac_tx.md
# i2s_dac_tx

Audio sample serializer driving the WM8731 DAC in I2S, 24-bit, slave mode, the format programmed by the codec configuration block. It sits downstream of the waveform source and beside the I2C configuration block. It waits for configuration to complete, then generates XCK, BCLK and DACLRCK from the 50 MHz system clock and shifts left/right sample pairs accepted over a valid/ready stream. Frame rate is clk/1024 = 48.828 kHz, which the codec treats as its 48 kHz, 256fs setting.

## Interface
- DATA_W, 24: sample width per channel.
- CLK_PER_BCLK, 16: system clocks per BCLK period; must be a power of two ≥ 4.
- SLOT_W, 32: BCLK periods per channel slot (64 per frame).
- clk  in  1  50 MHz system clock.
- rst  in  1  reset, asynchronous, active-high.
- cfg_done  in  1  codec configuration complete; level, from the I2C configuration block.
- s_left  in  DATA_W  left sample, two's complement.
- s_right  in  DATA_W  right sample, two's complement.
- s_valid  in  1  sample pair valid.
- s_ready  out  1  pair accepted when s_valid && s_ready.
- aud_xck  out  1  codec master clock, clk/4.
- aud_bclk  out  1  bit clock, clk/CLK_PER_BCLK.
- aud_daclrck  out  1  0 = left slot, 1 = right slot.
- aud_dacdat  out  1  serial data, MSB first.
- underrun_cnt  out  16  frames sent without a fresh pair; saturates at 16'hFFFF.

## Operation
- Reset values: all outputs 0; s_ready 0; state IDLE; cnt 0; hold register empty; shift registers 0.
- FSM has two states:
  - IDLE: all aud_* outputs 0, s_ready 0, cnt held at 0. Moves to RUN on the first cycle with cfg_done=1.
  - RUN: leaves for IDLE on any cycle with cfg_done=0. The transition clears cnt, the hold register and the shift registers; underrun_cnt is kept.
- Phase counter cnt (10 bits) increments every clk in RUN and wraps 1023 → 0.
  - aud_xck = cnt[1], aud_bclk = cnt[3], aud_daclrck = cnt[9].
  - Slot bit index k = cnt[8:4].
- All aud_* outputs are flops, computed from the next cnt value, so they change on the same edge as cnt.
- Data: aud_dacdat = sample[DATA_W-k] for k = 1..24 of the current channel; 0 for k = 0 and k = 25..31.
  - This is the one-BCLK I2S delay after the LRCK edge.
  - Data changes only on BCLK falling edges (cnt[3:0]==0); the codec samples on rising edges.
- Input buffering: one-entry hold register. s_ready = RUN && hold empty.
- Frame load happens on the edge where cnt goes 1023 → 0. Priority:
  - Hold full: the pair moves from hold into the shift registers; hold becomes empty.
  - Else, s_valid=1: the input pair loads directly into the shift registers (bypass); hold stays empty. The handshake completes in that cycle.
  - Else: underrun. Shift registers load 0/0 and underrun_cnt increments, saturating.
- A handshake in any other cycle writes the hold register.

## Timing
- Entering RUN: the first aud_bclk rising edge is 8 clk after the cycle where cfg_done is sampled high.
- The first frame is silence (0/0) and does not count as an underrun. Its load boundary falls at cnt 1023 → 0 of the first full frame.
- Input-to-wire latency: a pair accepted into hold during frame N goes out in frame N+1. Its left MSB first appears at cnt=16, which is 16 clk after the load edge.
- Throughput: at most one pair per 1024 clk. s_ready stays low from acceptance until the next frame load.
- aud_daclrck toggles only at cnt[8:0]==0, which coincides with a BCLK falling edge.
- Asserting rst mid-frame forces every output to 0 immediately. There is no partial-frame completion.

## Structure
- Package audio_pkg: DATA_W, SLOT_W, CLK_PER_BCLK, the frame length (1024) and the state enum {IDLE, RUN}. Future ADC/receive blocks share this package.
- Sub-module i2s_phase_gen: cnt, XCK/BCLK/LRCK flops and the frame_load strobe. The top level holds the FSM, the hold register, the shift/mux logic and underrun_cnt.

## Test plan
- cfg_done held 0 for 5000 clk with s_valid=1 → all aud_* stay 0, s_ready=0, underrun_cnt=0.
- cfg_done=1, one pair (L=24'h800001, R=24'h7FFFFE) presented → decoding on aud_bclk rising edges yields exactly L in the left slot (bits 1..24) and R in the right slot; bits 0 and 25..31 are 0; aud_daclrck period is 1024 clk.
- Continuous s_valid with incrementing samples for 100 frames → every pair is serialized in order with none dropped and underrun_cnt=0. s_ready pulses once per frame.
- s_valid dropped for 3 frames → 3 zero frames are output and underrun_cnt=3. Streaming then resumes without slip.
- s_valid asserted only on the cnt=1023 cycle with hold empty → the bypass load is used and that pair appears in the immediately following frame.
- rst asserted at cnt=500, then released with cfg_done=1 → outputs 0 during reset, then an IDLE → RUN restart from cnt=0. Also: cfg_done dropped mid-frame → return to IDLE with underrun_cnt preserved.
